// File: rtl/axil_rd_demux.sv
// AXI-lite read demux: routes merged AR by address field, returns R in issue order.
// Optional R-path skid register enabled by defining AXIL_RD_DEMUX_RSP_REG_EN.
module axil_rd_demux #(
    parameter int NUM_DSTS        = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DST_SEL_LSB     = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          src_axi_araddr,
    input  logic                           src_axi_arvalid,
    output logic                           src_axi_arready,
    output logic [DATA_WIDTH-1:0]          src_axi_rdata,
    output logic [1:0]                     src_axi_rresp,
    output logic                           src_axi_rvalid,
    input  logic                           src_axi_rready,
    output logic [NUM_DSTS*ADDR_WIDTH-1:0] dst_axi_araddr,
    output logic [NUM_DSTS-1:0]            dst_axi_arvalid,
    input  logic [NUM_DSTS-1:0]            dst_axi_arready,
    input  logic [NUM_DSTS*DATA_WIDTH-1:0] dst_axi_rdata,
    input  logic [NUM_DSTS*2-1:0]          dst_axi_rresp,
    input  logic [NUM_DSTS-1:0]            dst_axi_rvalid,
    output logic [NUM_DSTS-1:0]            dst_axi_rready
);

    localparam int SEL_W = $clog2(NUM_DSTS + 1);
    localparam int PW    = $clog2(MAX_OUTSTANDING);
    localparam int CW    = PW + 1;

    logic [SEL_W-1:0] w_sel;
    logic             w_err;
    logic             w_full;
    logic             w_dst_rdy;
    logic             w_push;
    logic             w_pop;
    logic             w_hv;
    logic             w_herr;
    logic [SEL_W-1:0] w_hsel;
    logic             w_bvld;
    logic             w_bacc;
    logic [DATA_WIDTH-1:0] w_bdata;
    logic [1:0]            w_bresp;

    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [MAX_OUTSTANDING-1:0]            r_ferr;
    logic [MAX_OUTSTANDING-1:0][SEL_W-1:0] r_fsel;

    assign w_sel  = src_axi_araddr[DST_SEL_LSB +: SEL_W];
    assign w_err  = int'(w_sel) >= NUM_DSTS;
    assign w_full = r_cnt == CW'(MAX_OUTSTANDING);

    assign dst_axi_araddr = {NUM_DSTS{src_axi_araddr}};

    always_comb begin
        w_dst_rdy       = 1'b0;
        dst_axi_arvalid = '0;
        for (int i = 0; i < NUM_DSTS; i++) begin
            if (w_sel == SEL_W'(i)) begin
                w_dst_rdy          = dst_axi_arready[i];
                dst_axi_arvalid[i] = rst_n & src_axi_arvalid
                                   & ~w_full & ~w_err;
            end
        end
    end

    assign src_axi_arready = rst_n & ~w_full & (w_err | w_dst_rdy);
    assign w_push = src_axi_arvalid & src_axi_arready;

    assign w_hv   = rst_n & (r_cnt != '0);
    assign w_herr = r_ferr[r_rp];
    assign w_hsel = r_fsel[r_rp];

    // Only the head slave is ever given rready, which enforces issue order.
    always_comb begin
        w_bvld         = 1'b0;
        w_bdata        = '0;
        w_bresp        = 2'b00;
        dst_axi_rready = '0;
        if (w_hv) begin
            if (w_herr) begin
                w_bvld  = 1'b1;
                w_bresp = 2'b11;
            end else begin
                for (int i = 0; i < NUM_DSTS; i++) begin
                    if (w_hsel == SEL_W'(i)) begin
                        w_bvld            = dst_axi_rvalid[i];
                        w_bdata           = dst_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                        w_bresp           = dst_axi_rresp[i*2 +: 2];
                        dst_axi_rready[i] = w_bacc;
                    end
                end
            end
        end
    end

    assign w_pop = w_bvld & w_bacc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ferr <= '0;
            r_fsel <= '0;
        end else begin
            if (w_push) begin
                r_ferr[r_wp] <= w_err;
                r_fsel[r_wp] <= w_sel;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef AXIL_RD_DEMUX_RSP_REG_EN
    logic [1:0]                 r_sk_cnt;
    logic                       r_sk_wp;
    logic                       r_sk_rp;
    logic [1:0][DATA_WIDTH-1:0] r_sk_data;
    logic [1:0][1:0]            r_sk_resp;
    logic                       w_sk_out;

    // Readiness depends only on skid occupancy, so src_axi_rready never
    // reaches the slave rready path combinationally.
    assign w_bacc   = r_sk_cnt != 2'd2;
    assign w_sk_out = src_axi_rvalid & src_axi_rready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sk_cnt  <= '0;
            r_sk_wp   <= 1'b0;
            r_sk_rp   <= 1'b0;
            r_sk_data <= '0;
            r_sk_resp <= '0;
        end else begin
            if (w_pop) begin
                r_sk_data[r_sk_wp] <= w_bdata;
                r_sk_resp[r_sk_wp] <= w_bresp;
                r_sk_wp            <= ~r_sk_wp;
            end
            if (w_sk_out) begin
                r_sk_rp <= ~r_sk_rp;
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, w_pop} - {1'b0, w_sk_out};
        end
    end

    assign src_axi_rvalid = rst_n & (r_sk_cnt != '0);
    assign src_axi_rdata  = r_sk_data[r_sk_rp];
    assign src_axi_rresp  = r_sk_resp[r_sk_rp];
`else
    assign w_bacc         = src_axi_rready;
    assign src_axi_rvalid = w_bvld;
    assign src_axi_rdata  = w_bdata;
    assign src_axi_rresp  = w_bresp;
`endif

endmodule

// File: tb/tb_axil_rd_demux.sv
// Bench for axil_rd_demux: directed steps plus random traffic against
// an issue-order response queue model and simple in-order slave models.
module tb_axil_rd_demux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_axi_araddr;
    logic        src_axi_arvalid;
    logic        src_axi_arready;
    logic [31:0] src_axi_rdata;
    logic [1:0]  src_axi_rresp;
    logic        src_axi_rvalid;
    logic        src_axi_rready;
    logic [63:0] dst_axi_araddr;
    logic [1:0]  dst_axi_arvalid;
    logic [1:0]  dst_axi_arready;
    logic [63:0] dst_axi_rdata;
    logic [3:0]  dst_axi_rresp;
    logic [1:0]  dst_axi_rvalid;
    logic [1:0]  dst_axi_rready;

    axil_rd_demux #(
        .NUM_DSTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .DST_SEL_LSB(12), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_axi_araddr(src_axi_araddr),
        .src_axi_arvalid(src_axi_arvalid),
        .src_axi_arready(src_axi_arready),
        .src_axi_rdata(src_axi_rdata),
        .src_axi_rresp(src_axi_rresp),
        .src_axi_rvalid(src_axi_rvalid),
        .src_axi_rready(src_axi_rready),
        .dst_axi_araddr(dst_axi_araddr),
        .dst_axi_arvalid(dst_axi_arvalid),
        .dst_axi_arready(dst_axi_arready),
        .dst_axi_rdata(dst_axi_rdata),
        .dst_axi_rresp(dst_axi_rresp),
        .dst_axi_rvalid(dst_axi_rvalid),
        .dst_axi_rready(dst_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] d; logic [1:0] r; bit err; int sel;} exp_t;
    typedef struct {logic [31:0] d; logic [1:0] r; int rdy;} sl_t;
    typedef struct {logic [31:0] d; logic [1:0] r; int c;} got_t;

    exp_t exq[$];
    sl_t  sq0[$];
    sl_t  sq1[$];
    got_t got_q[$];

    int cyc = 0;
    int nerr = 0;
    int nchk = 0;
    int ardy_mode [2];
    int lat_cfg [2];
    bit m_arhs;
    bit m_rhs;
    logic [1:0]  m_darhs;
    logic [1:0]  m_drhs;
    logic [31:0] m_daddr [2];

    function automatic logic [31:0] sdata(int i, logic [31:0] a);
        return a ^ 32'hA5A5_0000 ^ (32'(i) << 28);
    endfunction

    function automatic logic [1:0] sresp(logic [31:0] a);
        return a[4] ? 2'b10 : 2'b00;
    endfunction

    function automatic bit sl_rdy(int i);
        if (i == 0) return sq0.size() > 0 && sq0[0].rdy <= cyc;
        return sq1.size() > 0 && sq1[0].rdy <= cyc;
    endfunction

    function automatic sl_t sl_front(int i);
        return (i == 0) ? sq0[0] : sq1[0];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive slaves, settle, compare against the model, record handshakes.
    task automatic step_a();
        sl_t s;
        exp_t h;
        int sel;
        bit err, full;
        logic ardy, rv;
        logic [1:0] arv, rrdy, er;
        logic [31:0] ed;
        for (int i = 0; i < 2; i++) begin
            dst_axi_arready[i] = (ardy_mode[i] == 2) ?
                1'($urandom_range(0, 1)) : ardy_mode[i][0];
            if (sl_rdy(i)) begin
                s = sl_front(i);
                dst_axi_rvalid[i]       = 1'b1;
                dst_axi_rdata[i*32+:32] = s.d;
                dst_axi_rresp[i*2+:2]   = s.r;
            end else begin
                dst_axi_rvalid[i]       = 1'b0;
                dst_axi_rdata[i*32+:32] = $urandom;
                dst_axi_rresp[i*2+:2]   = 2'($urandom);
            end
        end
        #1;
        m_arhs = 0;
        m_rhs = 0;
        m_darhs = '0;
        m_drhs = '0;
        if (!rst_n) begin
            chk("rst_arready", src_axi_arready, 0);
            chk("rst_rvalid", src_axi_rvalid, 0);
            chk("rst_arvalid", dst_axi_arvalid, 0);
            chk("rst_rready", dst_axi_rready, 0);
        end else begin
            sel = int'(src_axi_araddr[13:12]);
            err = sel >= 2;
            full = exq.size() >= 4;
            ardy = !full && (err ? 1'b1 : dst_axi_arready[sel[0]]);
            arv = (src_axi_arvalid && !full && !err) ? 2'(1 << sel) : 2'b00;
            rv = 0;
            rrdy = '0;
            ed = '0;
            er = '0;
            if (exq.size() > 0) begin
                h = exq[0];
                if (h.err) begin
                    rv = 1;
                    er = 2'b11;
                end else begin
                    rv = sl_rdy(h.sel);
                    ed = h.d;
                    er = h.r;
                    rrdy = src_axi_rready ? 2'(1 << h.sel) : 2'b00;
                end
            end
            chk("arready", src_axi_arready, ardy);
            chk("arvalid", dst_axi_arvalid, arv);
            chk("rvalid", src_axi_rvalid, rv);
            chk("rready", dst_axi_rready, rrdy);
            if (rv) begin
                chk("rdata", src_axi_rdata, ed);
                chk("rresp", src_axi_rresp, er);
            end
            m_arhs = src_axi_arvalid && ardy;
            m_darhs = arv & dst_axi_arready;
            m_drhs = rrdy & dst_axi_rvalid;
            m_rhs = rv && src_axi_rready;
            m_daddr[0] = dst_axi_araddr[31:0];
            m_daddr[1] = dst_axi_araddr[63:32];
            if (src_axi_rvalid && src_axi_rready)
                got_q.push_back('{src_axi_rdata, src_axi_rresp, cyc});
        end
    endtask

    // Clock edge: advance the model by the handshakes seen this cycle.
    task automatic step_b();
        sl_t s;
        exp_t e;
        int sel;
        int lat;
        @(posedge clk);
        if (!rst_n) begin
            exq.delete();
            sq0.delete();
            sq1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_darhs[i]) begin
                    lat = (lat_cfg[i] == 0) ? $urandom_range(1, 4) : lat_cfg[i];
                    s.d = sdata(i, m_daddr[i]);
                    s.r = sresp(m_daddr[i]);
                    s.rdy = cyc + lat;
                    if (i == 0) sq0.push_back(s);
                    else sq1.push_back(s);
                end
                if (m_drhs[i]) begin
                    if (i == 0) void'(sq0.pop_front());
                    else void'(sq1.pop_front());
                end
            end
            if (m_rhs) void'(exq.pop_front());
            if (m_arhs) begin
                sel = int'(src_axi_araddr[13:12]);
                e.err = sel >= 2;
                e.sel = sel;
                e.d = e.err ? 32'h0 : sdata(sel, src_axi_araddr);
                e.r = e.err ? 2'b11 : sresp(src_axi_araddr);
                exq.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        step_a();
        step_b();
    endtask

    initial begin
        int c0;
        int issued;
        logic [31:0] t5a [16];

        src_axi_araddr = 32'h0;
        src_axi_arvalid = 1'b1;
        src_axi_rready = 1'b1;
        dst_axi_arready = '0;
        dst_axi_rvalid = '0;
        dst_axi_rdata = '0;
        dst_axi_rresp = '0;
        ardy_mode = '{1, 1};
        lat_cfg = '{2, 2};
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        src_axi_arvalid = 1'b0;
        tick();

        // single mapped read
        got_q.delete();
        src_axi_arvalid = 1'b1;
        src_axi_araddr = 32'h0000_0004;
        step_a();
        chk("t1_arvalid", dst_axi_arvalid, 2'b01);
        c0 = cyc;
        step_b();
        src_axi_arvalid = 1'b0;
        repeat (5) tick();
        chk("t1_beats", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("t1_data", got_q[0].d, 32'hA5A5_0004);
            chk("t1_resp", got_q[0].r, 2'b00);
            chk("t1_lat", got_q[0].c - c0, 2);
        end

        // decode error
        src_axi_arvalid = 1'b1;
        src_axi_araddr = 32'h0000_2000;
        step_a();
        chk("t2_arready", src_axi_arready, 1);
        chk("t2_arvalid", dst_axi_arvalid, 2'b00);
        step_b();
        src_axi_arvalid = 1'b0;
        step_a();
        chk("t2_rvalid", src_axi_rvalid, 1);
        chk("t2_rdata", src_axi_rdata, 32'h0);
        chk("t2_rresp", src_axi_rresp, 2'b11);
        step_b();
        repeat (2) tick();

        // out-of-order slaves, in-order return
        got_q.delete();
        lat_cfg = '{5, 1};
        src_axi_arvalid = 1'b1;
        src_axi_araddr = 32'h0000_0010;
        tick();
        src_axi_araddr = 32'h0000_1010;
        tick();
        src_axi_arvalid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step_a();
            if (dst_axi_rvalid[1] && got_q.size() == 0)
                chk("t3_hold", dst_axi_rready[1], 0);
            step_b();
        end
        chk("t3_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t3_first", got_q[0].d, 32'hA5A5_0010);
            chk("t3_second", got_q[1].d, 32'hB5A5_1010);
        end

        // full FIFO
        got_q.delete();
        lat_cfg = '{1, 1};
        src_axi_rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            src_axi_arvalid = 1'b1;
            src_axi_araddr = 32'(k * 4);
            step_a();
            chk("t4_accept", src_axi_arready, 1);
            step_b();
        end
        src_axi_araddr = 32'h0000_0020;
        repeat (3) begin
            step_a();
            chk("t4_full_arready", src_axi_arready, 0);
            chk("t4_full_arvalid", dst_axi_arvalid, 2'b00);
            step_b();
        end
        src_axi_rready = 1'b1;
        step_a();
        chk("t4_pop_rvalid", src_axi_rvalid, 1);
        chk("t4_pop_arready", src_axi_arready, 0);
        step_b();
        step_a();
        chk("t4_next_arready", src_axi_arready, 1);
        step_b();
        src_axi_arvalid = 1'b0;
        repeat (8) tick();
        chk("t4_beats", got_q.size(), 5);

        // back-to-back streaming
        got_q.delete();
        for (int k = 0; k < 16; k++) begin
            t5a[k] = 32'(k * 16) | (32'(k & 1) << 12);
            src_axi_arvalid = 1'b1;
            src_axi_araddr = t5a[k];
            step_a();
            chk("t5_accept", src_axi_arready, 1);
            step_b();
        end
        src_axi_arvalid = 1'b0;
        repeat (4) tick();
        chk("t5_beats", got_q.size(), 16);
        if (got_q.size() == 16) begin
            chk("t5_span", got_q[15].c - got_q[0].c, 15);
            for (int k = 0; k < 16; k++)
                chk("t5_order", got_q[k].d, sdata(k & 1, t5a[k]));
        end

        // reset mid-operation
        src_axi_rready = 1'b0;
        src_axi_arvalid = 1'b1;
        src_axi_araddr = 32'h0000_0040;
        tick();
        src_axi_araddr = 32'h0000_1040;
        tick();
        src_axi_araddr = 32'h0000_2000;
        tick();
        src_axi_arvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        src_axi_arvalid = 1'b1;
        src_axi_araddr = 32'h0;
        src_axi_rready = 1'b1;
        tick();
        rst_n = 1'b1;
        got_q.delete();
        tick();
        src_axi_arvalid = 1'b0;
        repeat (4) tick();
        chk("t6_beats", got_q.size(), 1);
        if (got_q.size() == 1)
            chk("t6_data", got_q[0].d, 32'hA5A5_0000);

        // randomized traffic
        got_q.delete();
        issued = 0;
        lat_cfg = '{0, 0};
        ardy_mode = '{2, 2};
        src_axi_arvalid = 1'b0;
        m_arhs = 0;
        for (int k = 0; k < 800; k++) begin
            if (!src_axi_arvalid || m_arhs) begin
                src_axi_arvalid = $urandom_range(0, 3) != 0;
                src_axi_araddr = ($urandom & 32'hFFFF_CFFF)
                               | (32'($urandom_range(0, 3)) << 12);
            end
            src_axi_rready = $urandom_range(0, 3) != 0;
            tick();
            if (m_arhs) issued++;
        end
        src_axi_arvalid = 1'b0;
        src_axi_rready = 1'b1;
        ardy_mode = '{1, 1};
        repeat (40) tick();
        chk("rand_beats", got_q.size(), issued);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/axil_rd_demux.md
Name: axil_rd_demux

Overview:
- Downstream neighbour of the AXI-lite read merge stage.
- Takes the single merged read master and routes each AR to one of NUM_DSTS AXI-lite read slaves by address field.
- Tracks outstanding reads in an in-order route FIFO and steers R responses back in issue order.
- Unmapped addresses get a locally generated DECERR.

Parameters:
- NUM_DSTS, 2, number of downstream read slaves (1..8).
- DATA_WIDTH, 32, read data width.
- ADDR_WIDTH, 32, address width.
- DST_SEL_LSB, 12, LSB of the address field used as destination index; field width SEL_W = $clog2(NUM_DSTS+1).
- MAX_OUTSTANDING, 4, route FIFO depth, power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- src_axi_araddr  in  ADDR_WIDTH  read address from merge stage
- src_axi_arvalid  in  1  AR valid
- src_axi_arready  out  1  AR ready
- src_axi_rdata  out  DATA_WIDTH  read data to merge stage
- src_axi_rresp  out  2  read response
- src_axi_rvalid  out  1  R valid
- src_axi_rready  in  1  R ready
- dst_axi_araddr  out  NUM_DSTS x ADDR_WIDTH  per-slave address (all carry src_axi_araddr)
- dst_axi_arvalid  out  NUM_DSTS  per-slave AR valid, one-hot or zero
- dst_axi_arready  in  NUM_DSTS  per-slave AR ready
- dst_axi_rdata  in  NUM_DSTS x DATA_WIDTH  per-slave read data
- dst_axi_rresp  in  NUM_DSTS x 2  per-slave response
- dst_axi_rvalid  in  NUM_DSTS  per-slave R valid
- dst_axi_rready  out  NUM_DSTS  per-slave R ready

Behaviour:
- Clock clk; reset rst_n, synchronous, active-low.
- Reset: route FIFO wr/rd pointers = 0, count = 0, all FIFO entries invalid.
- While rst_n low: src_axi_arready, src_axi_rvalid, dst_axi_arvalid, dst_axi_rready = 0.
- Reset mid-transaction drops all outstanding routes; slaves must be reset with the block.
- Decode: sel = src_axi_araddr[DST_SEL_LSB +: SEL_W].
  - sel < NUM_DSTS: mapped.
  - Otherwise: decode error, marked err.
- FIFO status: full = (count == MAX_OUTSTANDING). No push while full, even if a pop occurs the same cycle; this keeps the accept path off the R path.
- AR path, combinational, zero latency:
  - dst_axi_arvalid[i] = src_axi_arvalid & ~full & ~err & (sel == i).
  - src_axi_arready = ~full & (err | dst_axi_arready[sel]).
- Push on an AR handshake (src_axi_arvalid & src_axi_arready). Entry = {err, sel}.
- R path, serviced from the FIFO head only. Head entry = {h_err, h_sel}, valid when count > 0.
  - count == 0: src_axi_rvalid = 0, all dst_axi_rready = 0.
  - Head mapped: src_axi_rvalid = dst_axi_rvalid[h_sel]; rdata and rresp muxed from h_sel; dst_axi_rready[h_sel] = src_axi_rready; other rready bits = 0.
  - Head err: src_axi_rvalid = 1, rdata = 0, rresp = 2'b11 (DECERR); no dst rready asserted.
- Pop on an R handshake (src_axi_rvalid & src_axi_rready); rd pointer increments.
- Ordering: responses from non-head slaves are back-pressured (rready = 0) until they become head. Strict in-order return is guaranteed.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- Throughput: one AR per cycle and one R per cycle sustained when slaves respond in order.
- Latency: zero cycles added on AR and R (without the optional feature).
- A DECERR reaching the head completes in one cycle if src_axi_rready = 1.
- An AR with err is accepted in the same cycle it is presented, when not full.

Optional Feature:
- Macro: AXIL_RD_DEMUX_RSP_REG_EN.
- Defined: the R path toward src passes through a 2-entry skid register.
  - src_axi_rvalid, rdata and rresp come from flops.
  - Adds 1 cycle of R latency; full throughput is kept.
  - Head pop happens when the skid accepts the beat, not at the src handshake.
  - Skid-internal state resets to empty; src_axi_rvalid = 0 after reset.
- Undefined: R path is purely combinational as described above.

Test Plan (NUM_DSTS=2, DST_SEL_LSB=12, MAX_OUTSTANDING=4):
- Single mapped read: AR 0x0000_0004, dst0 arready=1, dst0 returns rdata 0xA5A5_0001 rresp 0 two cycles later -> dst_axi_arvalid = 2'b01 in the AR cycle; src sees rvalid with 0xA5A5_0001/OKAY; count returns to 0.
- Decode error: AR 0x0000_2000 (sel=2) -> accepted in the same cycle; no dst arvalid; next cycle src_axi_rvalid=1, rdata=0, rresp=2'b11.
- Out-of-order slaves: AR 0x0000_0010 (dst0), then AR 0x0000_1010 (dst1). dst1 raises rvalid first (0x1111_1111) while dst0 delays 5 cycles (0x0000_0000) -> dst_axi_rready[1] held 0 until the dst0 beat pops; src receives the dst0 data then 0x1111_1111.
- Full FIFO: 4 ARs to dst0 with src_axi_rready=0 -> 5th AR sees src_axi_arready=0 and dst arvalid=0 until a pop. In the pop cycle arready is still 0; the following cycle arready=1.
- Back-to-back streaming: 16 ARs alternating dst0/dst1, slaves return with 1-cycle latency, src_axi_rready=1 -> one R per cycle after fill; 16 beats returned in issue order.
- Reset mid-operation: 3 outstanding reads, assert rst_n=0 for 1 cycle -> all ready/valid outputs 0 during reset; count=0 after; the next AR 0x0000_0000 completes normally.
